// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, data width and overflow helper
package alu_pkg;

  localparam int DATA_W = 64;
  localparam int OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  // Subtraction is addition of ~b, so pass the effective sign of the second addend.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b_eff,
                                      input logic sign_r);
    return (sign_a == sign_b_eff) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operand/result handshake bundle for the ALU execute stage
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [OP_W-1:0]   in_op;
  logic              in_set_cc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

endinterface

// File: rtl/alu_exec_stage_alu.sv
// rtl/alu_exec_stage_alu.sv - combinational 64-bit add/sub/and/xor with signed overflow
module alu_64
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = a + b;
        ovf    = signed_ovf(a[DATA_W-1], b[DATA_W-1], result[DATA_W-1]);
      end
      OP_SUB: begin
        result = a - b;
        ovf    = signed_ovf(a[DATA_W-1], ~b[DATA_W-1], result[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - one-deep registered ALU execute stage with CCs and drain counter
// Optional condition-code register enabled by defining ALU_EXEC_CC_EN.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic [31:0]      op_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic [DATA_W-1:0] result_q;
  logic              ovf_q;
  logic              accept;
  logic              drain;

  alu_64 u_alu (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .op     (bus.in_op),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  assign bus.out_valid  = (state == ST_FULL);
  assign bus.in_ready   = !bus.out_valid || bus.out_ready;
  assign bus.out_result = result_q;
  assign bus.out_ovf    = ovf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;

  // A simultaneous drain and accept keeps the register full with the new beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      state    <= ST_FULL;
      result_q <= alu_result;
      ovf_q    <= alu_ovf;
    end else if (drain) begin
      state    <= ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (drain) begin
      op_count <= op_count + 32'd1;
    end
  end

`ifdef ALU_EXEC_CC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (accept && bus.in_set_cc) begin
      cc_zf <= (alu_result == '0);
      cc_sf <= alu_result[DATA_W-1];
      cc_of <= alu_ovf;
    end
  end
`else
  logic unused_set_cc;
  assign unused_set_cc = bus.in_set_cc;
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
  assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - vector-table and stall/reset sequence bench for alu_exec_stage
module tb_alu_exec_stage;
  import alu_pkg::*;

`ifdef ALU_EXEC_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] res;
    logic        ovf;
    logic        zf;
    logic        sf;
    logic        of;
  } vec_t;

  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        cc_zf, cc_sf, cc_of;
  logic [31:0] op_count;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [NV];

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cc_zf    (cc_zf),
    .cc_sf    (cc_sf),
    .cc_of    (cc_of),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic set_cc);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_set_cc = set_cc;
  endtask

  task automatic check_cc(input string name, input logic zf, input logic sf, input logic of);
    check({name, "_zf"}, 64'(cc_zf), 64'(CC_EN ? zf : 1'b0));
    check({name, "_sf"}, 64'(cc_sf), 64'(CC_EN ? sf : 1'b0));
    check({name, "_of"}, 64'(cc_of), 64'(CC_EN ? of : 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{OP_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{OP_ADD, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{OP_AND, 64'h497, 64'h423, 1'b0, 64'h403, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{OP_XOR, 64'h1234, 64'h1234, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{OP_AND, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{OP_XOR, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_set_cc = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check_cc("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back beats: each negedge checks the previous beat and offers the next.
    for (int i = 0; i <= NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("v%0d_out_valid", i - 1), 64'(bus.out_valid), 64'd1);
        check($sformatf("v%0d_in_ready", i - 1), 64'(bus.in_ready), 64'd1);
        check($sformatf("v%0d_result", i - 1), bus.out_result, vecs[i-1].res);
        check($sformatf("v%0d_ovf", i - 1), 64'(bus.out_ovf), 64'(vecs[i-1].ovf));
        check_cc($sformatf("v%0d", i - 1), vecs[i-1].zf, vecs[i-1].sf, vecs[i-1].of);
      end
      if (i < NV) drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].set_cc);
      else bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check("stream_drained", 64'(bus.out_valid), 64'd0);
    check("stream_op_count", 64'(op_count), 64'(NV));

    // Stall: result held while out_ready is low, second beat waits for the drain cycle.
    drive(OP_ADD, 64'd100, 64'd23, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(OP_SUB, 64'd50, 64'd8, 1'b0);
    #1;
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_in_ready0", 64'(bus.in_ready), 64'd0);
    check("stall_result0", bus.out_result, 64'd123);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready%0d", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_result%0d", k), bus.out_result, 64'd123);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("drain_in_ready", 64'(bus.in_ready), 64'd1);
    check("drain_result_held", bus.out_result, 64'd123);
    @(negedge clk);
    check("second_valid", 64'(bus.out_valid), 64'd1);
    check("second_result", bus.out_result, 64'd42);
    check("second_op_count", 64'(op_count), 64'(NV + 1));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("both_drained", 64'(bus.out_valid), 64'd0);
    check("both_op_count", 64'(op_count), 64'(NV + 2));
    check_cc("stall_cc", 1'b0, 1'b1, 1'b0);

    // Reset asserted while a result is stalled, between clock edges.
    drive(OP_ADD, 64'd7, 64'd8, 1'b1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    check_cc("pre_rst", 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_op_count", 64'(op_count), 64'd0);
    check("mid_rst_result", bus.out_result, 64'd0);
    check_cc("mid_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(OP_XOR, 64'd3, 64'd5, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check("post_rst_result", bus.out_result, 64'd6);
    check("post_rst_op_count0", 64'(op_count), 64'd0);
    check_cc("post_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("post_rst_drained", 64'(bus.out_valid), 64'd0);
    check("post_rst_op_count1", 64'(op_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-004 SHALL have port in_ready, output, 1 bit: stage can accept a beat.
REQ-005 SHALL have port in_a, input, 64 bits: signed operand A.
REQ-006 SHALL have port in_b, input, 64 bits: signed operand B.
REQ-007 SHALL have port in_op, input, 2 bits: operation select (00 add, 01 sub, 10 and, 11 xor).
REQ-008 SHALL have port in_set_cc, input, 1 bit: this beat updates the condition codes.
REQ-009 SHALL have port out_valid, output, 1 bit: result held.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_result, output, 64 bits: registered result.
REQ-012 SHALL have port out_ovf, output, 1 bit: registered signed overflow.
REQ-013 SHALL have ports cc_zf, cc_sf and cc_of, each an output of 1 bit: condition-code register.
REQ-014 SHALL have port op_count, output, 32 bits: number of results drained.

Function
REQ-015 SHALL implement a two-state holding register (EMPTY, FULL); out_valid = (state == FULL).
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL accept on in_valid && in_ready and present the result on out_result one cycle later (latency 1, throughput 1 per cycle).
REQ-018 SHALL make transitions: EMPTY→FULL on accept; FULL→EMPTY on out_ready without accept; FULL→FULL with a new result on simultaneous drain and accept.
REQ-019 SHALL hold out_result and out_ovf stable while out_valid && !out_ready.
REQ-020 SHALL compute add/sub modulo 2^64 (wrap).
REQ-021 SHALL set overflow for add when the operands have equal signs and the result sign differs from them.
REQ-022 SHALL compute sub as in_a - in_b and set overflow when the operand signs differ and the result sign differs from in_a.
REQ-023 SHALL force overflow to 0 for and/xor.
REQ-024 SHALL update the CCs only on an accepted beat with in_set_cc=1, in the same edge the result is captured: ZF = result==0, SF = result[63], OF = overflow.
REQ-025 SHALL increment op_count on each out_valid && out_ready cycle, wrapping 0xFFFFFFFF→0.

Reset
REQ-026 SHALL, while rst is high, set state EMPTY, out_valid 0, out_result 0, out_ovf 0, cc_zf 1, cc_sf 0, cc_of 0, and op_count 0 immediately, independent of clk.
REQ-027 SHALL discard an in-flight or stalled result when reset is asserted mid-operation; the first accept after rst deasserts behaves as from EMPTY.

Configuration
REQ-028 SHALL, with ALU_EXEC_CC_EN defined, implement the CC register per REQ-024.
REQ-029 SHALL, without ALU_EXEC_CC_EN, tie cc_zf/cc_sf/cc_of to 0 and ignore in_set_cc, with no CC flops generated; ports remain present.

Structure
REQ-030 SHALL take the opcode constants (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_XOR=11) and the data width (64) from the shared package alu_pkg.
REQ-031 SHALL instantiate the existing combinational alu_64 as its sole sub-module for result and overflow; the stage adds only handshake, registers, CC and counter.

Verification
REQ-032 SHALL cover: add 5 + (-7), set_cc=1 → out_result -2, out_ovf 0, SF 1, ZF 0, one cycle after accept.
REQ-033 SHALL cover: sub 0x8000_0000_0000_0000 - 1 → 0x7FFF_FFFF_FFFF_FFFF, out_ovf 1, OF 1.
REQ-034 SHALL cover: and 0x497 & 0x423 → 0x403; xor 0x1234 ^ 0x1234 with set_cc → 0, ZF 1, out_ovf 0.
REQ-035 SHALL cover: out_ready=0 for 3 cycles after an add, with a second beat offered → in_ready 0, result stable, second beat accepted on drain cycle, op_count +2 after both drain.
REQ-036 SHALL cover: beat with set_cc=0 after REQ-033 → CCs unchanged (OF stays 1).
REQ-037 SHALL cover: rst pulsed mid-stall → out_valid 0 and op_count 0 immediately, CCs at reset values.
